// File: rtl/pool2d_multichannel.sv
// rtl/pool2d_multichannel.sv - multi-channel 2-D average/max pooling engine
//
// Pools a C-channel HxW feature map with a KxK window and stride S, one
// window tap per cycle, all channels in parallel lanes.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        job request, sampled only while idle
//   mode         0 = average (round half up), 1 = max; latched at start
//   input_data   element (c,r,col) at ((c*H+r)*W+col)*DATA_WIDTH
//   output_data  pooled map, same layout with OUTPUT_H/OUTPUT_W
//   busy         high while a job is in progress
//   done         one-cycle completion pulse
module pool2d_multichannel #(
    parameter int H          = 3,
    parameter int W          = 4,
    parameter int C          = 1,
    parameter int K          = 2,
    parameter int S          = 1,
    parameter int DATA_WIDTH = 8,
    parameter int CEIL_MODE  = 0
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                start,
    input  logic                                                mode,
    input  logic [DATA_WIDTH*C*H*W-1:0]                         input_data,
    output logic [DATA_WIDTH*C*((CEIL_MODE != 0) ? ((H-K+S-1)/S+1) : ((H-K)/S+1))
                  *((CEIL_MODE != 0) ? ((W-K+S-1)/S+1) : ((W-K)/S+1))-1:0] output_data,
    output logic                                                busy,
    output logic                                                done
);

    localparam int OUTPUT_H = (CEIL_MODE != 0) ? ((H-K+S-1)/S+1) : ((H-K)/S+1);
    localparam int OUTPUT_W = (CEIL_MODE != 0) ? ((W-K+S-1)/S+1) : ((W-K)/S+1);
    localparam int KK       = K*K;
    localparam int SUM_W    = DATA_WIDTH + $clog2(KK) + 1;
    localparam int CNT_W    = $clog2(KK+1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_STORE, ST_FINISH} state_t;

    state_t                        r_state;
    state_t                        w_next;

    logic [DATA_WIDTH*C*H*W-1:0]   r_in;
    logic                          r_mode;
    logic [31:0]                   r_oh;
    logic [31:0]                   r_ow;
    logic [31:0]                   r_i;
    logic [31:0]                   r_j;
    logic [CNT_W-1:0]              r_cnt;
    logic [SUM_W-1:0]              r_sum [C];
    logic [DATA_WIDTH-1:0]         r_max [C];

    logic [31:0]                   w_row;
    logic [31:0]                   w_col;
    logic [31:0]                   w_row_s;
    logic [31:0]                   w_col_s;
    logic                          w_tap_valid;
    logic                          w_last_tap;
    logic                          w_last_pos;
    logic [CNT_W-1:0]              w_div;
    logic [DATA_WIDTH-1:0]         w_tap [C];
    logic [DATA_WIDTH-1:0]         w_avg [C];
    logic [DATA_WIDTH-1:0]         w_res [C];

    always_comb begin
        w_row       = r_oh*S + r_i;
        w_col       = r_ow*S + r_j;
        // Taps hanging past the border only exist in ceil mode; they are skipped.
        w_tap_valid = (w_row < H) && (w_col < W);
        // Clamp the address of skipped taps so the select never leaves the vector.
        w_row_s     = w_tap_valid ? w_row : 32'd0;
        w_col_s     = w_tap_valid ? w_col : 32'd0;
        w_last_tap  = (r_i == K-1) && (r_j == K-1);
        w_last_pos  = (r_oh == OUTPUT_H-1) && (r_ow == OUTPUT_W-1);
        // Count is at least 1 in STORE; the guard only keeps the divider defined elsewhere.
        w_div       = (r_cnt == '0) ? CNT_W'(1) : r_cnt;
        for (int c = 0; c < C; c++) begin
            w_tap[c] = w_tap_valid ?
                       r_in[((c*H + w_row_s)*W + w_col_s)*DATA_WIDTH +: DATA_WIDTH] : '0;
            w_avg[c] = DATA_WIDTH'((r_sum[c] + SUM_W'(r_cnt >> 1)) / SUM_W'(w_div));
            w_res[c] = r_mode ? r_max[c] : w_avg[c];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = ST_ACCUM;
            ST_ACCUM:  if (w_last_tap) w_next = ST_STORE;
            ST_STORE:  w_next = w_last_pos ? ST_FINISH : ST_ACCUM;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in        <= '0;
            r_mode      <= 1'b0;
            r_oh        <= '0;
            r_ow        <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            output_data <= '0;
            for (int c = 0; c < C; c++) begin
                r_sum[c] <= '0;
                r_max[c] <= '0;
            end
        end else begin
            done <= (r_state == ST_FINISH);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_in   <= input_data;
                        r_mode <= mode;
                        r_oh   <= '0;
                        r_ow   <= '0;
                        r_i    <= '0;
                        r_j    <= '0;
                        r_cnt  <= '0;
                        busy   <= 1'b1;
                        for (int c = 0; c < C; c++) begin
                            r_sum[c] <= '0;
                            r_max[c] <= '0;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (w_tap_valid) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        for (int c = 0; c < C; c++) begin
                            r_sum[c] <= r_sum[c] + SUM_W'(w_tap[c]);
                            if (w_tap[c] > r_max[c]) r_max[c] <= w_tap[c];
                        end
                    end
                    // j runs fastest; both indices return to 0 after the last tap.
                    if (r_j == K-1) begin
                        r_j <= '0;
                        r_i <= w_last_tap ? 32'd0 : r_i + 32'd1;
                    end else begin
                        r_j <= r_j + 32'd1;
                    end
                end
                ST_STORE: begin
                    for (int c = 0; c < C; c++) begin
                        output_data[((c*OUTPUT_H + r_oh)*OUTPUT_W + r_ow)*DATA_WIDTH +: DATA_WIDTH]
                            <= w_res[c];
                        r_sum[c] <= '0;
                        r_max[c] <= '0;
                    end
                    r_cnt <= '0;
                    if (r_ow == OUTPUT_W-1) begin
                        r_ow <= '0;
                        r_oh <= w_last_pos ? 32'd0 : r_oh + 32'd1;
                    end else begin
                        r_ow <= r_ow + 32'd1;
                    end
                end
                ST_FINISH: busy <= 1'b0;
                default:   busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_pool2d_multichannel.sv
// tb/tb_pool2d_multichannel.sv - scoreboard bench for pool2d_multichannel
module tb_pool2d_multichannel;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start0, mode0, busy0, done0;
    logic [95:0]  in0;
    logic [47:0]  out0;
    logic start1, mode1, busy1, done1;
    logic [95:0]  in1;
    logic [31:0]  out1;
    logic start2, mode2, busy2, done2;
    logic [191:0] in2;
    logic [95:0]  out2;

    pool2d_multichannel #(.H(3), .W(4), .C(1), .K(2), .S(1), .DATA_WIDTH(8), .CEIL_MODE(0)) u_floor (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .input_data(in0),
        .output_data(out0), .busy(busy0), .done(done0));

    pool2d_multichannel #(.H(3), .W(4), .C(1), .K(2), .S(2), .DATA_WIDTH(8), .CEIL_MODE(1)) u_ceil (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .input_data(in1),
        .output_data(out1), .busy(busy1), .done(done1));

    pool2d_multichannel #(.H(3), .W(4), .C(2), .K(2), .S(1), .DATA_WIDTH(8), .CEIL_MODE(0)) u_multi (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .input_data(in2),
        .output_data(out2), .busy(busy2), .done(done2));

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int g_map[2][3][4];

    int lit_avg_floor[6] = '{3, 4, 5, 7, 8, 9};
    int lit_max_floor[6] = '{5, 6, 7, 9, 10, 11};
    int lit_avg_ceil[4]  = '{3, 5, 9, 11};
    int lit_max_ceil[4]  = '{5, 7, 9, 11};

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int cfg_c(input int w);  return (w == 2) ? 2 : 1; endfunction
    function automatic int cfg_s(input int w);  return (w == 1) ? 2 : 1; endfunction
    function automatic int cfg_ow(input int w); return (w == 1) ? 2 : 3; endfunction

    task automatic set_in(input int w, input int c, input int r, input int col, input int v);
        int idx;
        idx = ((c*3 + r)*4 + col)*8;
        case (w)
            0:       in0[idx +: 8] = v[7:0];
            1:       in1[idx +: 8] = v[7:0];
            default: in2[idx +: 8] = v[7:0];
        endcase
    endtask

    function automatic int get_out(input int w, input int c, input int r, input int col);
        int idx;
        idx = ((c*2 + r)*cfg_ow(w) + col)*8;
        case (w)
            0:       return int'(out0[idx +: 8]);
            1:       return int'(out1[idx +: 8]);
            default: return int'(out2[idx +: 8]);
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 0) ? busy0 : (w == 1) ? busy1 : busy2;
    endfunction

    function automatic logic get_done(input int w);
        return (w == 0) ? done0 : (w == 1) ? done1 : done2;
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    task automatic set_mode(input int w, input logic v);
        case (w)
            0:       mode0 = v;
            1:       mode1 = v;
            default: mode2 = v;
        endcase
    endtask

    task automatic load_map(input int w);
        for (int c = 0; c < cfg_c(w); c++)
            for (int r = 0; r < 3; r++)
                for (int col = 0; col < 4; col++)
                    set_in(w, c, r, col, g_map[c][r][col]);
    endtask

    task automatic set_ramp();
        for (int r = 0; r < 3; r++)
            for (int col = 0; col < 4; col++) begin
                g_map[0][r][col] = 4*r + col;
                g_map[1][r][col] = 255;
            end
    endtask

    task automatic set_random();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 3; r++)
                for (int col = 0; col < 4; col++)
                    g_map[c][r][col] = int'($urandom_range(0, 255));
    endtask

    // Reference pooling over the bench's own copy of the map.
    function automatic int model(input int w, input int md, input int c, input int oh, input int ow);
        int sum, cnt, mx, r, cl, v;
        sum = 0; cnt = 0; mx = 0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                r  = oh*cfg_s(w) + i;
                cl = ow*cfg_s(w) + j;
                if (r < 3 && cl < 4) begin
                    v = g_map[c][r][cl];
                    sum += v;
                    cnt++;
                    if (v > mx) mx = v;
                end
            end
        return (md != 0) ? mx : (sum + cnt/2) / cnt;
    endfunction

    task automatic push_model(input int w, input int md);
        for (int c = 0; c < cfg_c(w); c++)
            for (int oh = 0; oh < 2; oh++)
                for (int ow = 0; ow < cfg_ow(w); ow++)
                    exp_q.push_back(model(w, md, c, oh, ow));
    endtask

    task automatic start_job(input int w, input logic md);
        load_map(w);
        set_mode(w, md);
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
    endtask

    task automatic wait_job(input int w, input string tag, input bit disturb);
        int e, done_n, busy_n, ovl, ex;
        e      = 2*cfg_ow(w)*5 + 1;
        done_n = -1;
        busy_n = 0;
        ovl    = 0;
        for (int n = 1; n <= e + 20; n++) begin
            @(posedge clk);
            #1;
            if (get_busy(w) && get_done(w)) ovl++;
            if (disturb && n == 4) begin
                set_start(w, 1'b1);
                set_mode(w, 1'b1);
                for (int c = 0; c < cfg_c(w); c++)
                    for (int r = 0; r < 3; r++)
                        for (int col = 0; col < 4; col++)
                            set_in(w, c, r, col, int'($urandom_range(0, 255)));
            end
            if (disturb && n == 5) set_start(w, 1'b0);
            if (get_done(w)) begin
                done_n = n;
                break;
            end
            if (get_busy(w)) busy_n++;
        end
        check_eq({tag, "_done_lat"}, done_n, e);
        check_eq({tag, "_busy_cycles"}, busy_n, e - 1);
        check_eq({tag, "_busy_done_overlap"}, ovl, 0);
        for (int c = 0; c < cfg_c(w); c++)
            for (int oh = 0; oh < 2; oh++)
                for (int ow = 0; ow < cfg_ow(w); ow++) begin
                    ex = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    check_eq($sformatf("%s_c%0d_%0d_%0d", tag, c, oh, ow), get_out(w, c, oh, ow), ex);
                end
    endtask

    task automatic watch_idle(input int w, input int ncyc, input string tag);
        int d, b;
        d = 0; b = 0;
        repeat (ncyc) begin
            @(posedge clk);
            #1;
            if (get_done(w)) d++;
            if (get_busy(w)) b++;
        end
        check_eq({tag, "_extra_done"}, d, 0);
        check_eq({tag, "_extra_busy"}, b, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        mode0  = 1'b0; mode1  = 1'b0; mode2  = 1'b0;
        in0 = '0; in1 = '0; in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 3; w++) begin
            check_eq($sformatf("rst_busy%0d", w), int'(get_busy(w)), 0);
            check_eq($sformatf("rst_done%0d", w), int'(get_done(w)), 0);
        end
        for (int ow = 0; ow < 3; ow++) check_eq($sformatf("rst_out_%0d", ow), get_out(0, 0, 0, ow), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Ramp map through every configuration, expectations written out by hand.
        set_ramp();
        foreach (lit_avg_floor[i]) exp_q.push_back(lit_avg_floor[i]);
        start_job(0, 1'b0);
        wait_job(0, "floor_avg", 1'b0);
        foreach (lit_max_floor[i]) exp_q.push_back(lit_max_floor[i]);
        start_job(0, 1'b1);
        wait_job(0, "floor_max", 1'b0);
        foreach (lit_avg_ceil[i]) exp_q.push_back(lit_avg_ceil[i]);
        start_job(1, 1'b0);
        wait_job(1, "ceil_avg", 1'b0);
        foreach (lit_max_ceil[i]) exp_q.push_back(lit_max_ceil[i]);
        start_job(1, 1'b1);
        wait_job(1, "ceil_max", 1'b0);
        foreach (lit_avg_floor[i]) exp_q.push_back(lit_avg_floor[i]);
        repeat (6) exp_q.push_back(255);
        start_job(2, 1'b0);
        wait_job(2, "multi_avg", 1'b0);

        // Random maps against the reference model.
        for (int w = 0; w < 3; w++)
            for (int md = 0; md < 2; md++) begin
                set_random();
                push_model(w, md);
                start_job(w, md[0]);
                wait_job(w, $sformatf("rand_w%0d_m%0d", w, md), 1'b0);
            end

        // Restart attempt and input/mode churn mid-job must not disturb the job.
        set_ramp();
        foreach (lit_avg_floor[i]) exp_q.push_back(lit_avg_floor[i]);
        start_job(0, 1'b0);
        wait_job(0, "hs_disturb", 1'b1);
        watch_idle(0, 40, "hs_after");

        // Back-to-back: next start lands on the idle cycle right after done.
        set_ramp();
        foreach (lit_max_floor[i]) exp_q.push_back(lit_max_floor[i]);
        start_job(0, 1'b1);
        wait_job(0, "b2b_first", 1'b0);
        foreach (lit_avg_floor[i]) exp_q.push_back(lit_avg_floor[i]);
        start_job(0, 1'b0);
        wait_job(0, "b2b_second", 1'b0);

        // Reset in the middle of a job.
        set_random();
        start_job(0, 1'b1);
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_busy", int'(busy0), 0);
        check_eq("midrst_done", int'(done0), 0);
        for (int oh = 0; oh < 2; oh++)
            for (int ow = 0; ow < 3; ow++)
                check_eq($sformatf("midrst_out_%0d_%0d", oh, ow), get_out(0, 0, oh, ow), 0);
        rst_n = 1'b1;
        watch_idle(0, 40, "midrst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pool2d_multichannel.md
# pool2d_multichannel

Parametrised multi-channel 2-D pooling engine. It computes either average or max pooling over a K×K window with stride S, optionally in ceil mode where edge windows hang past the input border. It processes all C channels in parallel lanes and visits one window tap per cycle. It sits in the pooling stage of the operator-verify datapath, consuming a flattened feature map and producing a flattened pooled map behind a start/done handshake.

## Interface
- `H`, 3, input height
- `W`, 4, input width
- `C`, 1, channel count (parallel lanes)
- `K`, 2, pooling window size (K ≤ H, K ≤ W)
- `S`, 1, stride (≥ 1)
- `DATA_WIDTH`, 8, unsigned element width
- `CEIL_MODE`, 0, 0: floor output size; 1: ceil output size with partial edge windows
- `OUTPUT_H`, derived, CEIL_MODE ? (H−K+S−1)/S+1 : (H−K)/S+1
- `OUTPUT_W`, derived, same rule with W
- `clk`  in  1  clock, all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  pulse; sampled only in IDLE
- `mode`  in  1  0 = average, 1 = max; latched at start
- `input_data`  in  DATA_WIDTH·C·H·W  vector [0:N−1]; element (c,r,col) at offset ((c·H+r)·W+col)·DATA_WIDTH, `+: DATA_WIDTH`
- `output_data`  out  DATA_WIDTH·C·OUTPUT_H·OUTPUT_W  same layout with OUTPUT_H/OUTPUT_W
- `busy`  out  1  high while a job is in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, ACCUM, STORE, FINISH.
- **IDLE**
  - On `start`: snapshot `input_data` and `mode` into internal registers, clear oh/ow/i/j and all lane accumulators, go to ACCUM.
  - `input_data` may change after the start edge.
- **ACCUM**
  - Each cycle handles tap (i,j), with j fastest, for every channel lane.
  - Tap row = oh·S+i, column = ow·S+j.
  - A tap with row ≥ H or column ≥ W is skipped: no sum, no count, no compare. This only happens when CEIL_MODE=1.
  - After tap (K−1,K−1), go to STORE. ACCUM always takes exactly K·K cycles.
- **STORE** (one cycle)
  - Write each lane result into `output_data[(c,oh,ow)]`.
  - Clear the accumulators.
  - Advance ow, then oh on wrap.
  - Go to FINISH if this was the last position (OUTPUT_H−1, OUTPUT_W−1), else go to ACCUM.
- **FINISH** (one cycle)
  - `done` = 1, `busy` = 0 next cycle.
  - Go to IDLE.
- **Average arithmetic**
  - Sum register width is DATA_WIDTH+$clog2(K·K)+1; it never overflows.
  - count = number of valid taps, 1..K·K. count ≥ 1 always holds by the output-size formula.
  - Result = (sum + count/2) / count, integer division, i.e. round-half-up. It always fits in DATA_WIDTH.
- **Max arithmetic**
  - Running max starts at 0; unsigned compare.
  - The result is the largest valid tap.
- **Boundary rules**
  - `start` while busy (ACCUM/STORE/FINISH) is ignored; no restart, no queueing.
  - `start` in the FINISH cycle is ignored.
  - `start` in the IDLE cycle after `done` is accepted, so back-to-back jobs are legal.
  - `output_data` updates position by position during a job. It is final when `done` is high and holds until the first STORE of the next job.
  - `mode` changes mid-job have no effect.

## Timing
- **Reset** (rst_n low at a rising edge): state = IDLE; `busy` = 0, `done` = 0, `output_data` = 0; all counters and accumulators are 0.
- Reset mid-job aborts the job immediately. No `done` is produced and the partial results are cleared.
- **Latency**
  - `start` sampled at edge T0 → `busy` high from T0+1.
  - `done` is high for exactly one cycle starting at edge T0 + OUTPUT_H·OUTPUT_W·(K·K+1) + 1.
  - `busy` falls together with `done` rising (busy and done are never both 1).
- Throughput: one job per OUTPUT_H·OUTPUT_W·(K·K+1)+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Average, floor mode**
  - Setup: H=3, W=4, K=2, S=1, C=1, element (r,c)=4r+c, mode=0.
  - Required: output 3,4,5,7,8,9 (half-up rounding of x.5).
  - Required: `done` at T0+31.
- **Max, floor mode**
  - Setup: same map, mode=1.
  - Required: output 5,6,7,9,10,11.
  - Required: `busy` is 1 for exactly 30 cycles.
- **Ceil mode**
  - Setup: H=3, W=4, K=2, S=2, CEIL_MODE=1, same map.
  - Required: OUTPUT 2×2.
  - Required avg: 3,5,9,11 (bottom windows divide by count 2: 17/2→9, 21/2→11).
  - Required max: 5,7,9,11.
- **Multi-channel**
  - Setup: C=2, channel 0 = ramp, channel 1 = all 255, avg.
  - Required: channel 1 outputs all 255 (no sum overflow).
  - Required: channel 0 output matches the single-channel result.
- **Handshake**
  - Stimulus: pulse `start` again at T0+5 and change `input_data`/`mode` mid-job.
  - Required: results are unchanged, only one `done` is produced, and a `start` on the IDLE cycle after `done` is accepted.
- **Reset mid-job**
  - Stimulus: assert `rst_n`=0 at T0+10 for one cycle.
  - Required: next cycle `busy`=0, `done`=0, `output_data`=0.
  - Required: no `done` pulse appears afterwards until a new `start`.
